// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - frame FSM state encoding (IDLE, DATA, PARITY, STOP)
//   - scancode prefix bytes (E0 = extended, F0 = break)
//   - ps2_width(): counter width needed to hold a value up to max_val
// No ports (package).
// -----------------------------------------------------------------------------
package ps2_pkg;

  typedef logic [1:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE   = 2'd0;
  localparam ps2_state_t ST_DATA   = 2'd1;
  localparam ps2_state_t ST_PARITY = 2'd2;
  localparam ps2_state_t ST_STOP   = 2'd3;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Bits needed for a counter that must reach max_val (never less than 1).
  function automatic int ps2_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// -----------------------------------------------------------------------------
// ps2_line_filter
// Two-flop synchroniser followed by a debouncer for one PS/2 line. The output
// only changes after FILT consecutive synchronised samples disagree with it;
// any agreeing sample restarts the count, so pulses shorter than FILT cycles
// never reach the output.
// Ports:
//   clk_sys  in   system clock
//   reset    in   synchronous active-high reset (output idles high)
//   line     in   raw asynchronous PS/2 line
//   filt     out  synchronised, debounced line
// -----------------------------------------------------------------------------
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILT = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic line,
  output logic filt
);

  localparam int CW = ps2_width(FILT);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: every register in a clocked block is assigned with <= so all flops
  // sample the pre-edge values; a blocking '=' here would collapse sync1 and
  // sync2 into a single stage.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // PS/2 lines idle high; resetting to 1 avoids a phantom falling edge.
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      filt  <= 1'b1;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        // This is the FILT-th disagreeing sample in a row.
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// -----------------------------------------------------------------------------
// ps2_kbd_rx
// Core-side PS/2 keyboard receiver. Filters the PS/2 clock/data pair,
// deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop),
// reports parity/framing errors, aborts stalled frames after TIMEOUT cycles
// and folds E0/F0 prefixes into single key events.
// Ports:
//   clk_sys       in   system clock
//   reset         in   synchronous active-high reset
//   ps2_clk       in   PS/2 clock, asynchronous, idles high
//   ps2_data      in   PS/2 data, asynchronous
//   rx_byte       out  last correctly received byte
//   rx_strobe     out  1-cycle pulse when rx_byte updates
//   parity_err    out  1-cycle pulse on parity failure
//   frame_err     out  1-cycle pulse on bad start/stop bit or timeout
//   key_code      out  scancode of the last key event
//   key_pressed   out  1 = make, 0 = break
//   key_extended  out  1 = E0-prefixed code
//   key_strobe    out  1-cycle pulse when key_* update
// -----------------------------------------------------------------------------
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILT    = 4,
  parameter int TIMEOUT = 20000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       parity_err,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_extended,
  output logic       key_strobe
);

  localparam int TW = ps2_width(TIMEOUT);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic clk_f;
  logic data_f;
  logic clk_q;
  logic fall;

  ps2_line_filter #(.FILT(FILT)) u_clk_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .line    (ps2_clk),
    .filt    (clk_f)
  );

  ps2_line_filter #(.FILT(FILT)) u_data_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .line    (ps2_data),
    .filt    (data_f)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_q <= 1'b1;
    end else begin
      clk_q <= clk_f;
    end
  end

  // Both lines pass through identical filters, so data_f is aligned with the
  // clock edge that the device intended to sample it on.
  assign fall = clk_q & ~clk_f;

  // ---------------------------------------------------------------------------
  // Frame FSM with stall timeout
  // ---------------------------------------------------------------------------
  ps2_state_t    state;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par_acc;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      shift      <= '0;
      par_acc    <= 1'b0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      rx_byte    <= '0;
      rx_strobe  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_strobe  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      // A fall takes priority over an expiring timeout in the same cycle.
      if (fall) begin
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!data_f) begin
              state   <= ST_DATA;
              bit_idx <= '0;
              par_acc <= 1'b0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          ST_DATA: begin
            shift   <= {data_f, shift[7:1]};
            par_acc <= par_acc ^ data_f;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_bit <= data_f;
            state   <= ST_STOP;
          end
          default: begin
            // Stop-bit error outranks parity: a broken frame says nothing
            // reliable about its parity.
            if (!data_f) begin
              frame_err <= 1'b1;
            end else if (par_acc ^ par_bit) begin
              rx_byte   <= shift;
              rx_strobe <= 1'b1;
            end else begin
              parity_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
        endcase
      end else if (state == ST_IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TW'(TIMEOUT - 1)) begin
        frame_err <= 1'b1;
        state     <= ST_IDLE;
        to_cnt    <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix decoder: consumes only accepted bytes, so errored frames never
  // disturb the prefix flags. Prefixes may arrive in either order.
  // ---------------------------------------------------------------------------
  logic ext_flag;
  logic brk_flag;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
      key_code     <= '0;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
      key_strobe   <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (rx_strobe) begin
        if (rx_byte == PS2_PREFIX_EXT) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == PS2_PREFIX_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          key_code     <= rx_byte;
          key_extended <= ext_flag;
          key_pressed  <= ~brk_flag;
          key_strobe   <= 1'b1;
          ext_flag     <= 1'b0;
          brk_flag     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_kbd_rx
// Directed bench for ps2_kbd_rx: good frames, prefix sequences, parity and
// framing errors, stall timeout, clock glitches and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_ps2_kbd_rx;

  localparam int FILT    = 4;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 20;   // clk_sys cycles per PS/2 clock half period

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] key_code;
  logic       key_pressed;
  logic       key_extended;
  logic       key_strobe;

  ps2_kbd_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .rx_byte      (rx_byte),
    .rx_strobe    (rx_strobe),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .key_code     (key_code),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .key_strobe   (key_strobe)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  // Cycle counter and pulse monitor (outputs sampled on the falling edge).
  int cyc = 0;
  int rx_cnt = 0, key_cnt = 0, perr_cnt = 0, ferr_cnt = 0;
  int last_rx_cyc = 0, last_key_cyc = 0, last_ferr_cyc = 0;
  int rx_base = 0, key_base = 0, perr_base = 0, ferr_base = 0;
  int last_fall_cyc = 0;

  always @(posedge clk_sys) cyc++;

  always @(negedge clk_sys) begin
    if (rx_strobe === 1'b1)  begin rx_cnt++;   last_rx_cyc   = cyc; end
    if (key_strobe === 1'b1) begin key_cnt++;  last_key_cyc  = cyc; end
    if (parity_err === 1'b1) begin perr_cnt++; end
    if (frame_err === 1'b1)  begin ferr_cnt++; last_ferr_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares pulse counts seen since the previous call.
  task automatic expect_counts(input string tag, input int rx, input int key,
                               input int perr, input int ferr);
    check({tag, ".rx_strobe"},  rx_cnt   - rx_base,   rx);
    check({tag, ".key_strobe"}, key_cnt  - key_base,  key);
    check({tag, ".parity_err"}, perr_cnt - perr_base, perr);
    check({tag, ".frame_err"},  ferr_cnt - ferr_base, ferr);
    rx_base   = rx_cnt;
    key_base  = key_cnt;
    perr_base = perr_cnt;
    ferr_base = ferr_cnt;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Drives n bits LSB first; data set while clock high, sampled on the fall.
  // With glitch set, a 2-cycle low pulse is injected in the high phase of bit 4.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (glitch && i == 4) begin
        wait_cycles(8);
        ps2_clk = 1'b0;
        wait_cycles(2);
        ps2_clk = 1'b1;
        wait_cycles(HALF - 10);
      end else begin
        wait_cycles(HALF);
      end
      ps2_clk       = 1'b0;
      last_fall_cyc = cyc;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic par, input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  // Well-formed frame with odd parity, followed by idle time for the pipeline.
  task automatic send_good(input logic [7:0] b);
    send_bits(frame(b, ~^b, 1'b1), 11, 1'b0);
    wait_cycles(30);
  endtask

  initial begin
    bit in_window;

    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(5);

    // Reset state
    check("reset.rx_byte",      rx_byte,      8'h00);
    check("reset.rx_strobe",    rx_strobe,    1'b0);
    check("reset.parity_err",   parity_err,   1'b0);
    check("reset.frame_err",    frame_err,    1'b0);
    check("reset.key_code",     key_code,     8'h00);
    check("reset.key_pressed",  key_pressed,  1'b0);
    check("reset.key_extended", key_extended, 1'b0);
    check("reset.key_strobe",   key_strobe,   1'b0);
    reset = 1'b0;
    wait_cycles(10);
    expect_counts("idle", 0, 0, 0, 0);

    // Plain make code 0x1C (three 1s -> parity bit 0)
    send_good(8'h1C);
    expect_counts("make1c", 1, 1, 0, 0);
    check("make1c.rx_byte",      rx_byte,      8'h1C);
    check("make1c.key_code",     key_code,     8'h1C);
    check("make1c.key_pressed",  key_pressed,  1'b1);
    check("make1c.key_extended", key_extended, 1'b0);
    check("make1c.key_latency",  last_key_cyc - last_rx_cyc, 1);

    // E0 F0 75 -> one extended break event
    send_good(8'hE0);
    expect_counts("pre_e0", 1, 0, 0, 0);
    send_good(8'hF0);
    expect_counts("pre_f0", 1, 0, 0, 0);
    check("pre_f0.rx_byte", rx_byte, 8'hF0);
    send_good(8'h75);
    expect_counts("brk75", 1, 1, 0, 0);
    check("brk75.key_code",     key_code,     8'h75);
    check("brk75.key_pressed",  key_pressed,  1'b0);
    check("brk75.key_extended", key_extended, 1'b1);

    // Flags cleared after the event
    send_good(8'h1C);
    expect_counts("after75", 1, 1, 0, 0);
    check("after75.key_extended", key_extended, 1'b0);
    check("after75.key_pressed",  key_pressed,  1'b1);

    // F0 E0 74 -> also extended break
    send_good(8'hF0);
    send_good(8'hE0);
    send_good(8'h74);
    expect_counts("f0e0_74", 3, 1, 0, 0);
    check("f0e0_74.key_code",     key_code,     8'h74);
    check("f0e0_74.key_pressed",  key_pressed,  1'b0);
    check("f0e0_74.key_extended", key_extended, 1'b1);

    // 0x1C with wrong parity bit 1
    send_bits(frame(8'h1C, 1'b1, 1'b1), 11, 1'b0);
    wait_cycles(30);
    expect_counts("badpar", 0, 0, 1, 0);
    check("badpar.rx_byte_kept", rx_byte, 8'h74);

    // Next good frame 0x29 decodes normally
    send_good(8'h29);
    expect_counts("good29", 1, 1, 0, 0);
    check("good29.key_code",    key_code,    8'h29);
    check("good29.key_pressed", key_pressed, 1'b1);

    // Stop bit 0
    send_bits(frame(8'h33, ~^8'h33, 1'b0), 11, 1'b0);
    wait_cycles(30);
    expect_counts("badstop", 0, 0, 0, 1);

    // Start bit 1 while idle
    send_bits(11'h001, 1, 1'b0);
    wait_cycles(30);
    expect_counts("badstart", 0, 0, 0, 1);

    // E0 prefix, then a frame stalled after 4 data bits; prefix must survive
    send_good(8'hE0);
    expect_counts("to_pre", 1, 0, 0, 0);
    send_bits(frame(8'h0A, 1'b0, 1'b1), 5, 1'b0);
    wait_cycles(TIMEOUT + 40);
    expect_counts("timeout", 0, 0, 0, 1);
    in_window = (last_ferr_cyc - last_fall_cyc >= TIMEOUT) &&
                (last_ferr_cyc - last_fall_cyc <= TIMEOUT + 20);
    check("timeout.window", in_window, 1'b1);
    send_good(8'h29);
    expect_counts("after_to", 1, 1, 0, 0);
    check("after_to.key_code",     key_code,     8'h29);
    check("after_to.key_extended", key_extended, 1'b1);

    // Short clock glitch mid-frame is filtered out (0x5A: four 1s -> parity 1)
    send_bits(frame(8'h5A, 1'b1, 1'b1), 11, 1'b1);
    wait_cycles(30);
    expect_counts("glitch", 1, 1, 0, 0);
    check("glitch.rx_byte", rx_byte, 8'h5A);

    // F0 prefix, partial frame, then reset: no pulses, all outputs cleared
    send_good(8'hF0);
    expect_counts("rst_pre", 1, 0, 0, 0);
    send_bits(frame(8'hFF, 1'b1, 1'b1), 4, 1'b0);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(TIMEOUT + 40);
    expect_counts("midreset", 0, 0, 0, 0);
    check("midreset.rx_byte",     rx_byte,     8'h00);
    check("midreset.key_code",    key_code,    8'h00);
    check("midreset.key_pressed", key_pressed, 1'b0);
    send_good(8'h1C);
    expect_counts("post_rst", 1, 1, 0, 0);
    check("post_rst.rx_byte",      rx_byte,      8'h1C);
    check("post_rst.key_pressed",  key_pressed,  1'b1);
    check("post_rst.key_extended", key_extended, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
